// File: rtl/uart_drain_pkg.sv
// Shared types and constants for the UART receive-buffer drain arbiter.
package uart_drain_pkg;

  localparam int unsigned NCH_DEFAULT = 5;
  localparam int unsigned CH_W        = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    READ = 2'd2,
    GAP  = 2'd3
  } drainState_e;

endpackage

// File: rtl/uart_buf_drain_arb_rr_pick.sv
// Round-robin first-pending search: lowest offset from ptr whose req bit is set.
module rr_pick
  import uart_drain_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT
) (
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    int unsigned pos;
    pos     = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NCH) pos = pos - NCH;
      if (!any && req[CH_W'(pos)]) begin
        gnt_idx = CH_W'(pos);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_buf_drain_arb.sv
// Drains full UART receive buffers one packet at a time, round-robin across
// channels, with a fixed idle gap between packets and sticky overrun flags.
module uart_buf_drain_arb
  import uart_drain_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEFAULT,
  parameter int unsigned AW      = 5,
  parameter int unsigned PKT_LEN = 24,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  done,
  input  logic            frame_start,
  input  logic            sink_ready,
  output logic [NCH-1:0]  rd_en,
  output logic [AW-1:0]   rd_addr,
  output logic            q_valid,
  output logic [CH_W-1:0] q_ch,
  output logic            q_last,
  output logic            busy,
  output logic [NCH-1:0]  overrun
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(PKT_LEN - 1);
  localparam logic [3:0]    GAP_LAST  = 4'(GAP_CYC - 1);

  drainState_e     state;
  drainState_e     nextState;
  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  pendingNext;
  logic [NCH-1:0]  overrunSet;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] pickIdx;
  logic            pickAny;
  logic [3:0]      gapCnt;
  logic            issue;
  logic            lastIssue;

  rr_pick #(.NCH(NCH)) uPick (
    .req     (pending),
    .ptr     (ptr),
    .gnt_idx (pickIdx),
    .any     (pickAny)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next state and read-issue decode; a stalled sink simply holds READ
  always_comb begin
    nextState = state;
    issue     = 1'b0;
    lastIssue = 1'b0;
    case (state)
      IDLE: if (|pending) nextState = ARB;
      ARB:  nextState = pickAny ? READ : IDLE;
      READ: begin
        if (sink_ready) begin
          issue = 1'b1;
          if (rd_addr == LAST_ADDR) begin
            lastIssue = 1'b1;
            nextState = (GAP_CYC == 0) ? ARB : GAP;
          end
        end
      end
      GAP:  if (gapCnt == GAP_LAST) nextState = ARB;
      default: nextState = IDLE;
    endcase
  end

  // Read enable follows sink_ready in the same cycle so the RAM byte lands next cycle
  assign rd_en = issue ? (NCH'(1) << grant) : '0;

  // A new done wins over frame_start; a done on the channel being drained is an overrun
  always_comb begin
    pendingNext = pending;
    if (frame_start) pendingNext = '0;
    if (state == ARB && pickAny) pendingNext[pickIdx] = 1'b0;
    pendingNext = pendingNext | done;
    overrunSet  = done & pending;
    if (state == READ) overrunSet = overrunSet | (done & (NCH'(1) << grant));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      overrun <= '0;
      ptr     <= '0;
      grant   <= '0;
      rd_addr <= '0;
      gapCnt  <= '0;
      busy    <= 1'b0;
      q_valid <= 1'b0;
      q_ch    <= '0;
      q_last  <= 1'b0;
    end else begin
      pending <= pendingNext;
      overrun <= overrun | overrunSet;
      busy    <= (nextState != IDLE);
      q_valid <= issue;
      q_ch    <= issue ? grant : '0;
      q_last  <= lastIssue;
      if (state == ARB && pickAny) begin
        grant <= pickIdx;
        ptr   <= (pickIdx == CH_W'(NCH - 1)) ? '0 : pickIdx + CH_W'(1);
      end
      if (issue) rd_addr <= lastIssue ? '0 : rd_addr + AW'(1);
      gapCnt <= (state == GAP) ? gapCnt + 4'd1 : 4'd0;
    end
  end

endmodule

// File: doc/uart_buf_drain_arb.md
UART_BUF_DRAIN_ARB -- requirements
Module: uart_buf_drain_arb

Interface
REQ-001 SHALL have parameter NCH, default 5, number of UART receive buffers.
REQ-002 SHALL have parameter AW, default 5, buffer address width (32 bytes).
REQ-003 SHALL have parameter PKT_LEN, default 24, bytes drained per packet (1..2^AW).
REQ-004 SHALL have parameter GAP_CYC, default 2, idle cycles between packets (0..15).
REQ-005 SHALL have port clk  in  1  system clock (80 MHz domain).
REQ-006 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-low.
REQ-007 SHALL have port done  in  NCH  per-channel single-cycle "buffer full" pulse from write-address counters.
REQ-008 SHALL have port frame_start  in  1  single-cycle pulse marking a new request cycle.
REQ-009 SHALL have port sink_ready  in  1  packer accepts a byte next cycle.
REQ-010 SHALL have port rd_en  out  NCH  one-hot buffer read enable.
REQ-011 SHALL have port rd_addr  out  AW  shared buffer read address.
REQ-012 SHALL have port q_valid  out  1  buffer output byte valid (rd_en delayed 1 cycle).
REQ-013 SHALL have port q_ch  out  3  channel index of the q_valid byte.
REQ-014 SHALL have port q_last  out  1  q_valid byte is the packet's last.
REQ-015 SHALL have port busy  out  1  high outside IDLE.
REQ-016 SHALL have port overrun  out  NCH  sticky per-channel overrun flags.

Function
REQ-017 SHALL keep pending[NCH]: set by done[i]; cleared at grant of channel i.
REQ-018 SHALL run FSM IDLE -> ARB -> READ -> GAP -> ARB/IDLE.
REQ-019 IDLE: go to ARB when any pending bit is set.
REQ-020 ARB, one cycle: grant the first pending channel searching round-robin from ptr; set ptr = grant+1 mod NCH; clear that pending bit; go to READ; with none pending, go to IDLE.
REQ-021 READ: each cycle sink_ready=1, drive rd_en[grant]=1 at rd_addr, then increment rd_addr.
REQ-022 READ: with sink_ready=0, rd_en=0 and rd_addr held (stall, no byte lost).
REQ-023 READ ends after the PKT_LEN-th issued read (addr PKT_LEN-1); rd_addr returns to 0; go to GAP.
REQ-024 GAP: hold GAP_CYC cycles with rd_en=0, then go to ARB; with GAP_CYC=0, go straight to ARB.
REQ-025 q_valid, q_ch and q_last SHALL be registered copies of the issue cycle, exactly 1 cycle later, aligned to the 1-cycle RAM output.
REQ-026 done[i] with pending[i] already set SHALL set overrun[i]; pending stays 1.
REQ-027 done[grant] during READ SHALL set pending[grant] and overrun[grant] (buffer overwritten mid-drain); the current read completes unchanged.
REQ-028 frame_start SHALL clear all pending bits except those set by done in the same cycle; the granted read completes.
REQ-029 overrun SHALL clear only on reset.
REQ-030 rd_en SHALL never have more than one bit set.

Reset
REQ-031 On rst=0: FSM IDLE, ptr=0, pending=0, overrun=0, rd_en=0, rd_addr=0, q_valid=0, q_ch=0, q_last=0, busy=0.
REQ-032 Reset asserted mid-READ SHALL abort the packet immediately; no further q_valid after release.

Structure
REQ-033 FSM state enum, NCH default and channel-index width SHALL live in shared package uart_drain_pkg.
REQ-034 Round-robin first-pending search SHALL be sub-module rr_pick (inputs req and ptr; outputs gnt_idx and any).

Verification
REQ-035 Verify: done[2] pulse, sink_ready=1 -> rd_en[2] for 24 cycles, addr 0..23; q_valid 1 cycle later; q_last on addr 23; q_ch=2.
REQ-036 Verify: done=5'b10011 in the same cycle -> grant order 0,1,4; 2 gap cycles between packets; busy drops after the third packet.
REQ-037 Verify: sink_ready low 3 cycles at addr 10 -> rd_addr held at 10; exactly 24 q_valid bytes; no duplicates.
REQ-038 Verify: done[3] twice before grant -> overrun[3]=1 and one packet only; done[1] during ch1 read -> overrun[1]=1 and a second ch1 packet.
REQ-039 Verify: frame_start during ch0 read with ch4 pending -> ch0 finishes; ch4 not granted; FSM returns to IDLE.
REQ-040 Verify: rst low at addr 12 -> all outputs 0 asynchronously; after release, no q_valid until a new done.
